// File: rtl/sbus_ahbl_manager_bridge.sv
// sbus_ahbl_manager_bridge: SBUS initiator to AHB-Lite manager, one single transfer in flight.
// All AHB outputs and SBUS responses are registered.
module sbus_ahbl_manager_bridge #(
    parameter int         W_ADDR = 32,
    parameter logic [3:0] HPROT  = 4'b0011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] sbus_addr,
    input  logic              sbus_write,
    input  logic [1:0]        sbus_size,
    input  logic              sbus_vld,
    input  logic [31:0]       sbus_wdata,
    output logic              sbus_rdy,
    output logic              sbus_err,
    output logic [31:0]       sbus_rdata,
    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    output logic [31:0]       ahblm_hwdata,
    input  logic [31:0]       ahblm_hrdata
);
    typedef enum logic [1:0] {IDLE, APHASE, DPHASE, RESP} state_t;
    state_t      state;
    logic [31:0] wdata_q;
    logic        drop;
    logic        illegal;
    assign illegal = sbus_size == 2'd3 || (sbus_size == 2'd1 && sbus_addr[0])
                     || (sbus_size == 2'd2 && sbus_addr[1:0] != 2'b00);
    assign ahblm_hburst = 3'b000;
    assign ahblm_hprot  = HPROT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wdata_q      <= '0;
            drop         <= 1'b0;
            sbus_rdy     <= 1'b0;
            sbus_err     <= 1'b0;
            sbus_rdata   <= '0;
            ahblm_haddr  <= '0;
            ahblm_hwrite <= 1'b0;
            ahblm_htrans <= 2'b00;
            ahblm_hsize  <= 3'b000;
            ahblm_hwdata <= '0;
        end else begin
            case (state)
                IDLE: if (sbus_vld) begin
                    if (illegal) begin
                        sbus_rdy   <= 1'b1;
                        sbus_err   <= 1'b1;
                        sbus_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        ahblm_haddr  <= sbus_addr;
                        ahblm_hwrite <= sbus_write;
                        ahblm_hsize  <= {1'b0, sbus_size};
                        ahblm_htrans <= 2'b10;
                        wdata_q      <= sbus_wdata;
                        drop         <= 1'b0;
                        state        <= APHASE;
                    end
                end
                APHASE: begin
                    drop <= drop | !sbus_vld;
                    if (ahblm_hready) begin
                        ahblm_htrans <= 2'b00;
                        ahblm_hwdata <= ahblm_hwrite ? wdata_q : 32'h0;
                        state        <= DPHASE;
                    end
                end
                DPHASE: begin
                    drop <= drop | !sbus_vld;
                    // a withdrawn request still finishes on the bus but gets no response pulse
                    if (ahblm_hready) begin
                        ahblm_hwdata <= '0;
                        sbus_rdata   <= ahblm_hresp ? 32'h0 : ahblm_hrdata;
                        sbus_err     <= ahblm_hresp;
                        sbus_rdy     <= !(drop | !sbus_vld);
                        state        <= RESP;
                    end
                end
                RESP: begin
                    sbus_rdy   <= 1'b0;
                    sbus_err   <= 1'b0;
                    sbus_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sbus_ahbl_manager_bridge.sv
// tb_sbus_ahbl_manager_bridge: directed checks of the SBUS to AHB-Lite bridge.
module tb_sbus_ahbl_manager_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sbus_addr = '0;
    logic        sbus_write = 1'b0;
    logic [1:0]  sbus_size = '0;
    logic        sbus_vld = 1'b0;
    logic [31:0] sbus_wdata = '0;
    logic        sbus_rdy, sbus_err;
    logic [31:0] sbus_rdata;
    logic [31:0] ahblm_haddr;
    logic        ahblm_hwrite;
    logic [1:0]  ahblm_htrans;
    logic [2:0]  ahblm_hsize, ahblm_hburst;
    logic [3:0]  ahblm_hprot;
    logic        ahblm_hready = 1'b1;
    logic        ahblm_hresp = 1'b0;
    logic [31:0] ahblm_hwdata;
    logic [31:0] ahblm_hrdata = '0;
    int          errors = 0;
    int          checks = 0;

    sbus_ahbl_manager_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .sbus_addr(sbus_addr), .sbus_write(sbus_write), .sbus_size(sbus_size),
        .sbus_vld(sbus_vld), .sbus_wdata(sbus_wdata),
        .sbus_rdy(sbus_rdy), .sbus_err(sbus_err), .sbus_rdata(sbus_rdata),
        .ahblm_haddr(ahblm_haddr), .ahblm_hwrite(ahblm_hwrite), .ahblm_htrans(ahblm_htrans),
        .ahblm_hsize(ahblm_hsize), .ahblm_hburst(ahblm_hburst), .ahblm_hprot(ahblm_hprot),
        .ahblm_hready(ahblm_hready), .ahblm_hresp(ahblm_hresp),
        .ahblm_hwdata(ahblm_hwdata), .ahblm_hrdata(ahblm_hrdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [1:0] s, input logic [31:0] d);
        sbus_addr = a; sbus_write = w; sbus_size = s; sbus_wdata = d; sbus_vld = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_rdy", 32'(sbus_rdy), 0);
        chk("rst_err", 32'(sbus_err), 0);
        chk("rst_htrans", 32'(ahblm_htrans), 0);
        chk("rst_haddr", ahblm_haddr, 0);
        chk("rst_hwdata", ahblm_hwdata, 0);
        tick; tick;
        rst_n = 1'b1;
        tick;
        // 1: word read, zero wait states
        ahblm_hrdata = 32'hCAFEF00D;
        req(32'h100, 1'b0, 2'd2, 32'h0);
        tick;
        chk("t1_c1_htrans", 32'(ahblm_htrans), 2);
        chk("t1_c1_haddr", ahblm_haddr, 32'h100);
        chk("t1_c1_hsize", 32'(ahblm_hsize), 2);
        chk("t1_c1_hwrite", 32'(ahblm_hwrite), 0);
        chk("t1_hburst", 32'(ahblm_hburst), 0);
        chk("t1_hprot", 32'(ahblm_hprot), 4'b0011);
        tick;
        chk("t1_c2_htrans", 32'(ahblm_htrans), 0);
        chk("t1_c2_hwdata", ahblm_hwdata, 0);
        chk("t1_c2_rdy", 32'(sbus_rdy), 0);
        tick;
        chk("t1_c3_rdy", 32'(sbus_rdy), 1);
        chk("t1_c3_err", 32'(sbus_err), 0);
        chk("t1_c3_rdata", sbus_rdata, 32'hCAFEF00D);
        sbus_vld = 1'b0;
        tick;
        chk("t1_c4_rdy", 32'(sbus_rdy), 0);
        // 2: byte write with 2 data-phase wait states
        req(32'h103, 1'b1, 2'd0, 32'h5A5A5A5A);
        tick;
        chk("t2_c1_htrans", 32'(ahblm_htrans), 2);
        chk("t2_c1_hsize", 32'(ahblm_hsize), 0);
        chk("t2_c1_hwrite", 32'(ahblm_hwrite), 1);
        tick;
        ahblm_hready = 1'b0;
        chk("t2_c2_hwdata", ahblm_hwdata, 32'h5A5A5A5A);
        tick;
        chk("t2_c3_hwdata", ahblm_hwdata, 32'h5A5A5A5A);
        chk("t2_c3_rdy", 32'(sbus_rdy), 0);
        tick;
        chk("t2_c4_hwdata", ahblm_hwdata, 32'h5A5A5A5A);
        chk("t2_c4_rdy", 32'(sbus_rdy), 0);
        ahblm_hready = 1'b1;
        tick;
        chk("t2_c5_rdy", 32'(sbus_rdy), 1);
        chk("t2_c5_err", 32'(sbus_err), 0);
        chk("t2_c5_hwdata", ahblm_hwdata, 0);
        sbus_vld = 1'b0;
        tick;
        // 3: read with two-cycle ERROR response
        ahblm_hrdata = 32'h12345678;
        req(32'h104, 1'b0, 2'd2, 32'h0);
        tick;
        chk("t3_c1_htrans", 32'(ahblm_htrans), 2);
        tick;
        ahblm_hresp = 1'b1; ahblm_hready = 1'b0;
        tick;
        chk("t3_c3_rdy", 32'(sbus_rdy), 0);
        chk("t3_c3_htrans", 32'(ahblm_htrans), 0);
        ahblm_hready = 1'b1;
        tick;
        chk("t3_c4_rdy", 32'(sbus_rdy), 1);
        chk("t3_c4_err", 32'(sbus_err), 1);
        chk("t3_c4_rdata", sbus_rdata, 0);
        sbus_vld = 1'b0; ahblm_hresp = 1'b0;
        tick;
        chk("t3_c5_rdy", 32'(sbus_rdy), 0);
        // 4: misaligned halfword, then illegal size
        req(32'h201, 1'b0, 2'd1, 32'h0);
        tick;
        chk("t4a_rdy", 32'(sbus_rdy), 1);
        chk("t4a_err", 32'(sbus_err), 1);
        chk("t4a_rdata", sbus_rdata, 0);
        chk("t4a_htrans", 32'(ahblm_htrans), 0);
        chk("t4a_haddr_hold", ahblm_haddr, 32'h104);
        sbus_vld = 1'b0;
        tick;
        chk("t4a_rdy_off", 32'(sbus_rdy), 0);
        req(32'h0, 1'b1, 2'd3, 32'hFFFFFFFF);
        tick;
        chk("t4b_rdy", 32'(sbus_rdy), 1);
        chk("t4b_err", 32'(sbus_err), 1);
        chk("t4b_htrans", 32'(ahblm_htrans), 0);
        chk("t4b_hwdata", ahblm_hwdata, 0);
        sbus_vld = 1'b0;
        tick;
        chk("t4b_rdy_off", 32'(sbus_rdy), 0);
        // 5: withdraw during address phase stalled 3 cycles
        ahblm_hready = 1'b0;
        req(32'h108, 1'b0, 2'd2, 32'h0);
        tick;
        chk("t5_c1_htrans", 32'(ahblm_htrans), 2);
        sbus_vld = 1'b0;
        tick;
        chk("t5_c2_htrans", 32'(ahblm_htrans), 2);
        chk("t5_c2_haddr", ahblm_haddr, 32'h108);
        tick;
        chk("t5_c3_htrans", 32'(ahblm_htrans), 2);
        ahblm_hready = 1'b1;
        tick;
        chk("t5_c4_htrans", 32'(ahblm_htrans), 0);
        chk("t5_c4_rdy", 32'(sbus_rdy), 0);
        tick;
        chk("t5_c5_rdy", 32'(sbus_rdy), 0);
        tick;
        chk("t5_c6_rdy", 32'(sbus_rdy), 0);
        // 6: reset during data phase, then a normal request
        req(32'h300, 1'b1, 2'd2, 32'h11223344);
        tick;
        tick;
        ahblm_hready = 1'b0;
        chk("t6_pre_hwdata", ahblm_hwdata, 32'h11223344);
        rst_n = 1'b0; sbus_vld = 1'b0;
        #1;
        chk("t6_rst_htrans", 32'(ahblm_htrans), 0);
        chk("t6_rst_hwdata", ahblm_hwdata, 0);
        chk("t6_rst_haddr", ahblm_haddr, 0);
        chk("t6_rst_rdy", 32'(sbus_rdy), 0);
        tick;
        rst_n = 1'b1; ahblm_hready = 1'b1;
        tick;
        chk("t6_after_rdy", 32'(sbus_rdy), 0);
        ahblm_hrdata = 32'hDEADBEEF;
        req(32'h10, 1'b0, 2'd2, 32'h0);
        tick;
        chk("t6_n_htrans", 32'(ahblm_htrans), 2);
        tick;
        tick;
        chk("t6_n_rdy", 32'(sbus_rdy), 1);
        chk("t6_n_rdata", sbus_rdata, 32'hDEADBEEF);
        sbus_vld = 1'b0;
        tick;
        chk("t6_n_rdy_off", 32'(sbus_rdy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
